imm_gen_pipe: RTL

Registered, parametrised immediate generator for the decode stage. Accepts instruction bits `instr[31:7]` plus an immediate-type select over a valid/ready handshake. Produces an XLEN-wide extended immediate one cycle later, with an optional pass-through tag.
Extends the RV32 I/S/B/U/J set with CSR zimm and shift-amount types, an illegal-select error flag, flush support and an accepted-beat counter.

---
 rtl/imm_gen_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RV32/RV64 immediate generator with valid/ready handshake, flush and beat counter.
// Define IMM_GEN_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:7]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] beat_cnt
);

    logic            sign;
    logic [31:0]     imm32;
    logic            next_err;
    logic [XLEN-1:0] next_imm;
    logic            accept;
    logic            fire;

    assign sign = instr[31];

    // Every RV32 form fits in 32 bits; Z and SH keep bit 31 clear, so one sign-extend serves all types.
    always_comb begin
        imm32    = '0;
        next_err = 1'b0;
        case (imm_src)
            3'd0: imm32 = {{20{sign}}, instr[31:20]};
            3'd1: imm32 = {{20{sign}}, instr[31:25], instr[11:7]};
            3'd2: imm32 = {{20{sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'd3: imm32 = {instr[31:12], 12'b0};
            3'd4: imm32 = {{12{sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            3'd5: imm32 = {27'd0, instr[19:15]};
            3'd6: imm32 = (XLEN == 64) ? {26'd0, instr[25:20]} : {27'd0, instr[24:20]};
            default: next_err = 1'b1;
        endcase
    end

    assign next_imm = XLEN'($signed(imm32));
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid & out_ready;

`ifdef IMM_GEN_SKID_EN
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;

    assign in_ready = ~flush & ~skid_valid;

    // Skid only fills while the output is stalled, so it always holds the younger beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_err   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_imm    <= skid_imm;
                out_tag    <= skid_tag;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_imm   <= next_imm;
                out_tag   <= in_tag;
                out_err   <= next_err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= next_imm;
            skid_tag   <= in_tag;
            skid_err   <= next_err;
        end
    end
`else
    assign in_ready = ~flush & (~out_valid | out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_imm   <= next_imm;
            out_tag   <= in_tag;
            out_err   <= next_err;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end
`endif

    // Flush already gates in_ready, so the counter never sees a flushed beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule
